// File: rtl/macfile_multi_if.sv
// Bundle of the MAC-pipeline, divider and read-port signals of the multi-accumulator file.
// The slave side is the register file; the master side is the pipeline/divider that drives it.
interface macfile_multi_if #(
  parameter int NUM_ACC = 4,
  parameter int ACC_W   = 40,
  parameter int DATA_W  = 32,
  parameter int IW      = 2
);
  logic               HOLD;
  logic [1:0]         MAC_WE;
  logic [IW-1:0]      MAC_IDX;
  logic [ACC_W-1:0]   MAC_HI;
  logic [ACC_W-1:0]   MAC_LO;
  logic               DIV_VALID;
  logic               DIV_READY;
  logic [1:0]         DIV_WE;
  logic [IW-1:0]      DIV_IDX;
  logic [ACC_W-1:0]   DIV_HI;
  logic [ACC_W-1:0]   DIV_LO;
  logic [1:0]         SRCA_SEL;
  logic [1:0]         SRCB_SEL;
  logic [IW-1:0]      SRCA_IDX;
  logic [IW-1:0]      SRCB_IDX;
  logic [ACC_W-1:0]   SRCA_DATA;
  logic [ACC_W-1:0]   SRCB_DATA;
  logic [1:0]         RES_SEL;
  logic [IW-1:0]      RES_IDX_H;
  logic [IW-1:0]      RES_IDX_L;
  logic [3:0]         RES_SH_H;
  logic [3:0]         RES_SH_L;
  logic               RES_SAT;
  logic [DATA_W-1:0]  RES_DATA;
  logic               RES_OVF;
  logic [NUM_ACC-1:0] ACC_BUSY;

  modport slave (
    input  HOLD, MAC_WE, MAC_IDX, MAC_HI, MAC_LO,
    input  DIV_VALID, DIV_WE, DIV_IDX, DIV_HI, DIV_LO,
    input  SRCA_SEL, SRCB_SEL, SRCA_IDX, SRCB_IDX,
    input  RES_SEL, RES_IDX_H, RES_IDX_L, RES_SH_H, RES_SH_L, RES_SAT,
    output DIV_READY, SRCA_DATA, SRCB_DATA, RES_DATA, RES_OVF, ACC_BUSY
  );

  modport master (
    output HOLD, MAC_WE, MAC_IDX, MAC_HI, MAC_LO,
    output DIV_VALID, DIV_WE, DIV_IDX, DIV_HI, DIV_LO,
    output SRCA_SEL, SRCB_SEL, SRCA_IDX, SRCB_IDX,
    output RES_SEL, RES_IDX_H, RES_IDX_L, RES_SH_H, RES_SH_L, RES_SAT,
    input  DIV_READY, SRCA_DATA, SRCB_DATA, RES_DATA, RES_OVF, ACC_BUSY
  );
endinterface

// File: rtl/macfile_multi.sv
// Multi-accumulator MAC register file: NUM_ACC full-width H/L pairs, two operand ports,
// a shifted/saturating result port, and MAC/divider write arbitration with a one-deep park.
module macfile_multi #(
  parameter int NUM_ACC = 4,
  parameter int ACC_W   = 40,
  parameter int DATA_W  = 32,
  parameter int IW      = 2
) (
  input logic             CLK,
  input logic             RESET_D1_R,
  macfile_multi_if.slave  bus
);

  localparam logic [3:0]               SH_MAX  = 4'd8;
  localparam logic signed [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_h [NUM_ACC];
  logic signed [ACC_W-1:0] acc_l [NUM_ACC];

  logic                    pend_valid;
  logic [IW-1:0]           pend_idx;
  logic [1:0]              pend_we;
  logic signed [ACC_W-1:0] pend_hi;
  logic signed [ACC_W-1:0] pend_lo;

  function automatic logic signed [ACC_W-1:0] ash(input logic signed [ACC_W-1:0] v,
                                                  input logic [3:0] sh);
    logic [3:0] s;
    s = (sh > SH_MAX) ? SH_MAX : sh;
    return v >>> s;
  endfunction

  // Overflow when the bits above the result's sign bit disagree with it.
  function automatic logic ovf_chk(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-DATA_W:0] top;
    top = v[ACC_W-1:DATA_W-1];
    return !((&top) || !(|top));
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_win(input logic signed [ACC_W-1:0] v,
                                                       input logic sat);
    if (sat && ovf_chk(v)) return v[ACC_W-1] ? SAT_NEG : SAT_POS;
    return v[DATA_W-1:0];
  endfunction

  function automatic logic idx_ok(input logic [IW-1:0] idx);
    return int'(idx) < NUM_ACC;
  endfunction

  // Write arbitration: a parked divider write always takes precedence over a new request.
  logic [1:0]              mac_we_eff;
  logic                    div_act;
  logic [IW-1:0]           div_idx;
  logic [1:0]              div_we;
  logic signed [ACC_W-1:0] div_hi;
  logic signed [ACC_W-1:0] div_lo;
  logic                    conflict;
  logic                    div_commit;

  always_comb begin
    mac_we_eff = bus.MAC_WE & {2{~bus.HOLD}};
    div_act    = pend_valid | bus.DIV_VALID;
    div_idx    = pend_valid ? pend_idx : bus.DIV_IDX;
    div_we     = pend_valid ? pend_we  : bus.DIV_WE;
    div_hi     = pend_valid ? pend_hi  : bus.DIV_HI;
    div_lo     = pend_valid ? pend_lo  : bus.DIV_LO;
    conflict   = div_act && (bus.MAC_IDX == div_idx) && (|(mac_we_eff & div_we));
    div_commit = div_act && !conflict;
  end

  always_ff @(posedge CLK or posedge RESET_D1_R) begin
    if (RESET_D1_R) begin
      pend_valid <= 1'b0;
      for (int i = 0; i < NUM_ACC; i++) begin
        acc_h[i] <= '0;
        acc_l[i] <= '0;
      end
    end else begin
      if (pend_valid) begin
        if (!conflict) pend_valid <= 1'b0;
      end else if (bus.DIV_VALID && conflict) begin
        pend_valid <= 1'b1;
      end
      for (int i = 0; i < NUM_ACC; i++) begin
        if (mac_we_eff[1] && bus.MAC_IDX == IW'(i))
          acc_h[i] <= bus.MAC_HI;
        else if (div_commit && div_we[1] && div_idx == IW'(i))
          acc_h[i] <= div_hi;
        if (mac_we_eff[0] && bus.MAC_IDX == IW'(i))
          acc_l[i] <= bus.MAC_LO;
        else if (div_commit && div_we[0] && div_idx == IW'(i))
          acc_l[i] <= div_lo;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!pend_valid && bus.DIV_VALID && conflict) begin
      pend_idx <= bus.DIV_IDX;
      pend_we  <= bus.DIV_WE;
      pend_hi  <= bus.DIV_HI;
      pend_lo  <= bus.DIV_LO;
    end
  end

  // Read ports: stored values only; an unmatched index falls through to zero.
  logic signed [ACC_W-1:0] srca;
  logic signed [ACC_W-1:0] srcb;
  logic signed [ACC_W-1:0] raw_h;
  logic signed [ACC_W-1:0] raw_l;
  logic [NUM_ACC-1:0]      busy;

  always_comb begin
    srca  = '0;
    srcb  = '0;
    raw_h = '0;
    raw_l = '0;
    busy  = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (bus.SRCA_IDX == IW'(i))
        srca = (bus.SRCA_SEL == 2'b10) ? acc_h[i] : (bus.SRCA_SEL == 2'b01) ? acc_l[i] : '0;
      if (bus.SRCB_IDX == IW'(i))
        srcb = (bus.SRCB_SEL == 2'b10) ? acc_h[i] : (bus.SRCB_SEL == 2'b01) ? acc_l[i] : '0;
      if (bus.RES_IDX_H == IW'(i)) raw_h = acc_h[i];
      if (bus.RES_IDX_L == IW'(i)) raw_l = acc_l[i];
      busy[i] = pend_valid && (pend_idx == IW'(i));
    end
  end

  logic signed [ACC_W-1:0]  val_h;
  logic signed [ACC_W-1:0]  val_l;
  logic signed [DATA_W-1:0] win_h;
  logic signed [DATA_W-1:0] win_l;
  logic                     ovf_h;
  logic                     ovf_l;
  logic [DATA_W-1:0]        res;
  logic                     res_ovf;

  always_comb begin
    val_h   = ash(raw_h, bus.RES_SH_H);
    val_l   = ash(raw_l, bus.RES_SH_L);
    win_h   = sat_win(val_h, bus.RES_SAT);
    win_l   = sat_win(val_l, bus.RES_SAT);
    ovf_h   = ovf_chk(val_h);
    ovf_l   = ovf_chk(val_l);
    res     = '0;
    res_ovf = 1'b0;
    case (bus.RES_SEL)
      2'b01: begin
        res     = win_l;
        res_ovf = ovf_l;
      end
      2'b10: begin
        res     = win_h;
        res_ovf = ovf_h;
      end
      2'b11: begin
        res     = {win_h[DATA_W-1 -: DATA_W/2], win_l[DATA_W-1 -: DATA_W/2]};
        res_ovf = ovf_h | ovf_l;
      end
      default: ;
    endcase
  end

  assign bus.SRCA_DATA = srca;
  assign bus.SRCB_DATA = srcb;
  assign bus.RES_DATA  = res;
  assign bus.RES_OVF   = res_ovf;
  assign bus.DIV_READY = ~pend_valid;
  assign bus.ACC_BUSY  = busy;

  a_res_shift : assert property (@(posedge CLK) disable iff (RESET_D1_R)
    (bus.RES_SH_H <= SH_MAX) && (bus.RES_SH_L <= SH_MAX));

  a_index_range : assert property (@(posedge CLK) disable iff (RESET_D1_R)
    (!(|bus.MAC_WE) || idx_ok(bus.MAC_IDX)) &&
    (!(bus.DIV_VALID && |bus.DIV_WE) || idx_ok(bus.DIV_IDX)) &&
    (!(|bus.SRCA_SEL) || idx_ok(bus.SRCA_IDX)) &&
    (!(|bus.SRCB_SEL) || idx_ok(bus.SRCB_IDX)) &&
    (!bus.RES_SEL[1] || idx_ok(bus.RES_IDX_H)) &&
    (!bus.RES_SEL[0] || idx_ok(bus.RES_IDX_L)));

  a_div_hold : assert property (@(posedge CLK) disable iff (RESET_D1_R)
    (bus.DIV_VALID && !bus.DIV_READY) |=>
      (bus.DIV_VALID && $stable({bus.DIV_WE, bus.DIV_IDX, bus.DIV_HI, bus.DIV_LO})));

endmodule

// File: doc/macfile_multi.md
# macfile_multi

Parametrised multi-accumulator MAC register file for the core's multiply-accumulate unit. It is the successor of the single-pair HI/LO file:
- holds NUM_ACC accumulator pairs (H and L) at full ACC_W guard width;
- serves two operand read ports and one shifted/saturating result read port;
- arbitrates MAC-pipeline and divider writes, parking a colliding divider write in a one-deep pending buffer under a valid/ready handshake.

It sits between the MAC datapath (C/E stages) and the iterative divider.

## Interface
Parameters:
- NUM_ACC, 4, number of accumulator pairs (1..4)
- ACC_W, 40, accumulator width including guard bits (33..48)
- DATA_W, 32, result width
- IW, 2, index width, max(1, clog2(NUM_ACC))

Ports:
- CLK  in  1  core clock; all state updates on rising edge
- RESET_D1_R  in  1  reset, asynchronous, active-high
- HOLD  in  1  pipeline hold; suppresses MAC writes only
- MAC_WE  in  2  MAC write enables {H,L}
- MAC_IDX  in  IW  MAC target accumulator
- MAC_HI, MAC_LO  in  ACC_W  MAC write data
- DIV_VALID  in  1  divider write request
- DIV_READY  out  1  divider write accepted when high with DIV_VALID
- DIV_WE  in  2  divider write enables {H,L}
- DIV_IDX  in  IW  divider target accumulator
- DIV_HI, DIV_LO  in  ACC_W  divider write data
- SRCA_SEL, SRCB_SEL  in  2  01=L, 10=H, else zero
- SRCA_IDX, SRCB_IDX  in  IW  operand accumulator index
- SRCA_DATA, SRCB_DATA  out  ACC_W  operand data (combinational)
- RES_SEL  in  2  11=packed {H[31:16],L[31:16]}, 01=L, 10=H, 00=zero
- RES_IDX_H, RES_IDX_L  in  IW  result H/L source index
- RES_SH_H, RES_SH_L  in  4  arithmetic right shift, 0..8
- RES_SAT  in  1  saturate result to DATA_W signed range
- RES_DATA  out  DATA_W  result (combinational)
- RES_OVF  out  1  selected result out of DATA_W range (before saturation)
- ACC_BUSY  out  NUM_ACC  accumulator has a parked divider write

## Operation
- Storage: acc_h[i] and acc_l[i], each ACC_W bits. Storage is full width; there is no truncation to 32 bits.
- Reads return stored values only. Pending data is not forwarded. Consumers interlock on ACC_BUSY.
- Operand ports: select by index and half. An illegal index (≥ NUM_ACC) or SEL=11 returns 0.
- Result path, per half:
  - value = acc >>> RES_SH (sign-extended from bit ACC_W-1); a shift above 8 is treated as 8.
  - win = value[DATA_W-1:0].
  - ovf = value[ACC_W-1:DATA_W-1] is not all-equal.
  - If RES_SAT and ovf: win = 0x7FFF_FFFF when value[ACC_W-1]=0, else 0x8000_0000.
- RES_OVF = OR of ovf over the halves used by RES_SEL. It is 0 when RES_SEL=00.
- Effective MAC write mask: MAC_WE & {2{~HOLD}}.
- Conflict: the effective MAC write and the divider write (incoming or pending) share an index and at least one half.
- A divider write is atomic: both of its halves are deferred together.
- Divider accept (DIV_VALID & DIV_READY):
  - no conflict: write the array at this edge;
  - conflict: capture {idx, we, hi, lo} into the pending buffer and set pend_valid.
- Pending buffer: drains at the first edge with no conflict against the effective MAC write, then clears pend_valid.
- DIV_READY = ~pend_valid.
- ACC_BUSY[i] = pend_valid & (pend_idx == i).
- A MAC and a divider write to different halves or different indices in the same cycle both commit.
- A divider write with DIV_WE=00 is accepted and has no effect.

## Timing
- Reset (asynchronous assert): all accumulators 0, pend_valid 0. Resulting outputs:
  - DIV_READY=1, ACC_BUSY=0;
  - SRCA_DATA=SRCB_DATA=0, RES_DATA=0, RES_OVF=0.
- Reset mid-operation discards any pending write.
- Write latency is 1: a write sampled at edge n is visible on the read ports after edge n.
- Conflict timeline:
  - collision at edge n → pending;
  - DIV_READY=0 and ACC_BUSY set from after edge n;
  - earliest drain at edge n+1;
  - DIV_READY returns to 1 after the drain edge.
- A new divider request cannot be accepted in the drain cycle.
- HOLD held high removes all conflicts, so the pending buffer drains at the next edge.
- A sustained MAC collision keeps the buffer parked indefinitely with no loss of data.
- Simulation-only checks:
  - RES_SH > 8;
  - any index ≥ NUM_ACC with an enable or select active;
  - DIV_VALID dropped or its data changed while DIV_READY=0.

## Test plan
- Reset: then SRCA_SEL=10, SRCA_IDX=3 → SRCA_DATA=0; DIV_READY=1; ACC_BUSY=0.
- Guard bits preserved: MAC writes acc_h[2]=0xFF_8000_0000. Read with SRCA_SEL=10, SRCA_IDX=2 → 0xFF_8000_0000. Result H with RES_SH_H=8 → RES_DATA=0xFF80_0000, RES_OVF=0.
- Saturation: acc_l[1]=0x01_0000_0000, RES_SEL=01, RES_SAT=1 → RES_DATA=0x7FFF_FFFF, RES_OVF=1. With RES_SAT=0 → RES_DATA=0x0000_0000, RES_OVF=1.
- Collision: same edge, MAC writes acc_l[0]=0x11 and divider writes {H,L}[0]={0x22,0x33}.
  - After the edge: acc_l[0]=0x11, acc_h[0] unchanged, ACC_BUSY=0001, DIV_READY=0.
  - Next edge (no MAC write): acc_h[0]=0x22, acc_l[0]=0x33, ACC_BUSY=0, DIV_READY=1.
- HOLD and parking: with HOLD=1 a colliding MAC write is suppressed and the divider write commits directly. Under a 5-cycle repeated MAC collision with HOLD=0 the pending write stays parked, then commits the first free cycle.
- Packed mode: acc_h[0]=0x00_1234_5678, acc_l[3]=0x00_9ABC_DEF0, RES_SEL=11, RES_IDX_H=0, RES_IDX_L=3 → RES_DATA=0x1234_9ABC. Asserting reset in the same cycle as a pending write → pending cleared, all accumulators 0.
